// File: rtl/inst_enc_pkg.sv
// Shared types and encoding constants for the MIPS instruction encoder.
// Op enum order matches the control decoder's 17-instruction subset.
package inst_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SLT  = 5'd4,
    OP_SRL  = 5'd5,
    OP_XOR  = 5'd6,
    OP_LW   = 5'd7,
    OP_SW   = 5'd8,
    OP_BEQ  = 5'd9,
    OP_BNE  = 5'd10,
    OP_J    = 5'd11,
    OP_ADDI = 5'd12,
    OP_ANDI = 5'd13,
    OP_ORI  = 5'd14,
    OP_SLTI = 5'd15,
    OP_XORI = 5'd16
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_XOR = 6'h26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational packer: symbolic op plus register/immediate fields -> 32-bit MIPS word.
// Ops outside the supported subset report legal=0 and a zero word.
module inst_field_pack
  import inst_enc_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word
);

  always_comb begin
    legal = 1'b1;
    word  = 32'h0;
    case (op)
      // shamt only carries meaning for SRL; rs is ignored by SRL
      OP_ADD:  word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      OP_SUB:  word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      OP_AND:  word = r_word(rs, rt, rd, 5'd0, FN_AND);
      OP_OR:   word = r_word(rs, rt, rd, 5'd0, FN_OR);
      OP_SLT:  word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      OP_SRL:  word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      OP_XOR:  word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      OP_LW:   word = i_word(OPC_LW, rs, rt, imm);
      OP_SW:   word = i_word(OPC_SW, rs, rt, imm);
      OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
      OP_BNE:  word = i_word(OPC_BNE, rs, rt, imm);
      OP_J:    word = {OPC_J, target};
      OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
      OP_ANDI: word = i_word(OPC_ANDI, rs, rt, imm);
      OP_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
      OP_SLTI: word = i_word(OPC_SLTI, rs, rt, imm);
      OP_XORI: word = i_word(OPC_XORI, rs, rt, imm);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streams encoded MIPS words into imem from base_addr; one word per accepted request, latency 1.
// Optional running XOR checksum of written words when INST_ENC_CHKSUM_EN is defined.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [31:0]       chksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(DEPTH - 1);

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] base_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;

  logic        pack_legal;
  logic [31:0] pack_word;
  logic        accept;
  logic        write_fire;

  inst_field_pack u_pack (
    .op     (req_op),
    .rs     (req_rs),
    .rt     (req_rt),
    .rd     (req_rd),
    .shamt  (req_shamt),
    .imm    (req_imm),
    .target (req_target),
    .legal  (pack_legal),
    .word   (pack_word)
  );

  // start has priority over any request presented in the same cycle
  assign req_ready  = (state_reg == ST_RUN) && !start;
  assign accept     = req_valid && req_ready;
  assign write_fire = accept && pack_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_RUN;
    end else if ((state_reg == ST_RUN) && write_fire && (count_reg == COUNT_LAST)) begin
      state_next = ST_FULL;
    end
  end

  // Write port: registered one cycle after the accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
    end else begin
      we_reg <= write_fire;
      if (write_fire) begin
        addr_reg  <= base_reg + count_reg[ADDR_W-1:0];
        wdata_reg <= pack_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (start) begin
      base_reg  <= base_addr;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (write_fire) begin
        count_reg <= count_reg + CNT_W'(1);
      end
      if (accept && !pack_legal) begin
        err_reg <= 1'b1;
      end
    end
  end

`ifdef INST_ENC_CHKSUM_EN
  logic [31:0] chksum_reg;

  // Updated on the accept edge so it already includes the word imem_we is presenting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chksum_reg <= 32'h0;
    end else if (start) begin
      chksum_reg <= 32'h0;
    end else if (write_fire) begin
      chksum_reg <= chksum_reg ^ pack_word;
    end
  end

  assign chksum = chksum_reg;
`else
  assign chksum = 32'h0;
`endif

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign word_count = count_reg;
  assign busy       = (state_reg == ST_RUN);
  assign full       = (state_reg == ST_FULL);
  assign err        = err_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder (DEPTH=4): directed scenarios followed by random requests.
module tb_inst_encoder;

  localparam int AW  = 8;
  localparam int DEP = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op, req_rs, req_rt, req_rd, req_shamt;
  logic [15:0]   req_imm;
  logic [25:0]   req_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          busy, full, err;
  logic [31:0]   chksum;

  inst_encoder #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .busy(busy), .full(full), .err(err), .chksum(chksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [AW:0]   cnt;
    logic [31:0]   chk;
  } exp_t;
  exp_t sb[$];

  // Reference model state, kept as plain flags and counters
  bit          m_busy, m_full, m_err;
  int          m_count;
  logic [7:0]  m_base;
  logic [31:0] m_chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_encode(input logic [4:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [15:0] imm, input logic [25:0] tg, output bit legal);
    int fn_tab [0:6];
    int opc_tab [0:16];
    fn_tab  = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h02, 'h26};
    opc_tab = '{0, 0, 0, 0, 0, 0, 0, 'h23, 'h2B, 'h04, 'h05, 'h02, 'h08, 'h0C, 'h0D, 'h0A, 'h0E};
    legal = (op < 5'd17);
    if (!legal) return 32'h0;
    if (op <= 5'd6) begin
      if (op == 5'd5)
        return (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn_tab[op]);
      return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn_tab[op]);
    end
    if (op == 5'd11) return (32'(opc_tab[op]) << 26) | 32'(tg);
    return (32'(opc_tab[op]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
  endfunction

  // One clock of stimulus: drive, check status at negedge, advance model, move past posedge
  task automatic cyc(input bit s, input logic [7:0] b, input bit v, input logic [4:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [15:0] imm, input logic [25:0] tg);
    bit          legal;
    logic [31:0] w;
    exp_t        e;
    start = s; base_addr = b; req_valid = v; req_op = op;
    req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh; req_imm = imm; req_target = tg;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(m_busy && !s));
    check("busy", 32'(busy), 32'(m_busy));
    check("full", 32'(full), 32'(m_full));
    check("err", 32'(err), 32'(m_err));
    check("word_count", 32'(word_count), 32'(m_count));
    if (s) begin
      m_busy = 1; m_full = 0; m_err = 0; m_count = 0; m_chk = 32'h0; m_base = b;
    end else if (v && m_busy) begin
      w = ref_encode(op, rs, rt, rd, sh, imm, tg, legal);
      if (legal) begin
        e.due  = cyc_n + 1;
        e.addr = m_base + 8'(m_count);
        m_count++;
        m_chk  = m_chk ^ w;
        e.data = w;
        e.cnt  = 9'(m_count);
        e.chk  = m_chk;
        sb.push_back(e);
        if (m_count == DEP) begin m_busy = 0; m_full = 1; end
      end else begin
        m_err = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] b);
    cyc(1, b, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
  endtask

  task automatic idle();
    cyc(0, 8'h0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
  endtask

  task automatic req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tg);
    cyc(0, 8'h0, 1, op, rs, rt, rd, sh, imm, tg);
  endtask

  // Monitor: every write the DUT presents must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due < cyc_n) begin
        check("write_missing_due", 32'(cyc_n), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (imem_we === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_we", 32'(imem_we), 32'h0);
        end else begin
          e = sb.pop_front();
          check("write_cycle", 32'(cyc_n), 32'(e.due));
          check("imem_addr", 32'(imem_addr), 32'(e.addr));
          check("imem_wdata", imem_wdata, e.data);
          check("count_at_write", 32'(word_count), 32'(e.cnt));
`ifdef INST_ENC_CHKSUM_EN
          check("chksum", chksum, e.chk);
`else
          check("chksum_tied", chksum, 32'h0);
`endif
          $display("write t=%0t addr=0x%02h data=0x%08h count=%0d", $time, imem_addr, imem_wdata, word_count);
        end
      end
    end
  end

  initial begin
    bit          s;
    logic [4:0]  op;
    rst_n = 1'b0;
    start = 0; base_addr = '0; req_valid = 0; req_op = '0; req_rs = '0; req_rt = '0;
    req_rd = '0; req_shamt = '0; req_imm = '0; req_target = '0;
    m_busy = 0; m_full = 0; m_err = 0; m_count = 0; m_base = 8'h0; m_chk = 32'h0;
    #12;
    check("rst_we", 32'(imem_we), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_count", 32'(word_count), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_chksum", chksum, 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // Basic stream: ADD, LW, J, ADDI -> fourth word reaches DEPTH
    go(8'h10);
    req(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);
    req(5'd7, 5'd9, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    req(5'd11, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100);
    req(5'd12, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005, 26'h0);
    idle(); idle();

    // Illegal op mid-stream, then legal op continues at the next address
    go(8'h30);
    req(5'd5, 5'd31, 5'd4, 5'd6, 5'd9, 16'h0, 26'h0);
    req(5'd20, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    req(5'd1, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'h0);
    idle();

    // Address wrap and FULL
    go(8'hFE);
    for (int i = 0; i < 4; i++) req(5'(13 + i), 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(16'hA5A0 + i), 26'h0);
    req(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    idle();
    go(8'h40);
    idle();

    // start collides with a request; in-flight write still lands at the old address
    go(8'h50);
    req(5'd2, 5'd6, 5'd7, 5'd8, 5'd0, 16'h0, 26'h0);
    cyc(1, 8'h60, 1, 5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    idle();
    req(5'd6, 5'd10, 5'd11, 5'd12, 5'd0, 16'h0, 26'h0);
    idle();

    // Asynchronous reset while a write is on the port
    go(8'h70);
    req(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(imem_we), 32'h0);
    check("midrst_count", 32'(word_count), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    sb.delete();
    m_busy = 0; m_full = 0; m_err = 0; m_count = 0; m_base = 8'h0; m_chk = 32'h0;
    start = 0; req_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 15) == 0) || (!m_busy && $urandom_range(0, 2) == 0);
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      cyc(s, 8'($urandom), ($urandom_range(0, 3) != 0), op, 5'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
    end
    idle(); idle(); idle();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
